// File: rtl/sb_sched_pkg.sv
// Shared widths and the FSM state type for the sideband TX scheduler.
package sb_sched_pkg;
  localparam int SB_PHASE_W   = 64;
  localparam int SB_GAP_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    PATTERN,
    HDR,
    DATA,
    GAP
  } sched_state_e;
endpackage

// File: rtl/sb_tx_scheduler_if.sv
// Requester / serializer / mux-select bundle of the sideband TX scheduler.
interface sb_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import sb_sched_pkg::*;

  // Handshake: a word on the line (o_pattern_valid or o_packet_valid) is consumed
  // only on a cycle where i_tx_ready=1; until then phase and valids are held.
  // i_req is a level; o_req_ack pulses for one cycle when the payload is captured.
  logic                          i_tx_ready;
  logic                          i_pattern_req;
  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*SB_PHASE_W-1:0] i_req_header;
  logic [NUM_REQ*SB_PHASE_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_has_data;
  logic [NUM_REQ-1:0]            o_req_ack;
  logic                          o_pattern_valid;
  logic                          o_packet_valid;
  logic [SB_PHASE_W-1:0]         o_packet_phase;
  logic                          o_busy;
  sched_state_e                  o_state;

  modport master (
    output i_tx_ready, i_pattern_req, i_req, i_req_header, i_req_data, i_req_has_data,
    input  o_req_ack, o_pattern_valid, o_packet_valid, o_packet_phase, o_busy, o_state
  );

  modport slave (
    input  i_tx_ready, i_pattern_req, i_req, i_req_header, i_req_data, i_req_has_data,
    output o_req_ack, o_pattern_valid, o_packet_valid, o_packet_phase, o_busy, o_state
  );
endinterface

// File: rtl/sb_rr_arbiter.sv
// Combinational one-hot arbiter. SB_SCHED_FIXED_PRIO_EN selects lowest-index-wins
// priority; otherwise the search starts at ptr and wraps (round-robin).
module sb_rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
`ifdef SB_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: shares the 64-bit phase path between the clock pattern
// and NUM_REQ packet requesters. SB_SCHED_FIXED_PRIO_EN removes the RR pointer.
module sb_tx_scheduler
  import sb_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic              i_clk,
  input logic              i_rst_n,
  sb_tx_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [SB_GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : SB_GAP_CNT_W'(GAP_CYCLES - 1);
  localparam sched_state_e POST_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  sched_state_e            state_q, state_d;
  logic [SB_GAP_CNT_W-1:0] gap_q, gap_d;
  logic [SB_PHASE_W-1:0]   data_q, phase_q, phase_d;
  logic                    has_data_q;
  logic [NUM_REQ-1:0]      grant, ack_d, ack_q;
  logic [PTR_W-1:0]        ptr;
  logic [SB_PHASE_W-1:0]   sel_hdr, sel_data;
  logic                    sel_has_data;
  logic                    take;
  logic                    pat_q, pkt_q, busy_q;

  sb_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.i_req),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    sel_hdr      = '0;
    sel_data     = '0;
    sel_has_data = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_hdr      = bus.i_req_header[i*SB_PHASE_W +: SB_PHASE_W];
        sel_data     = bus.i_req_data[i*SB_PHASE_W +: SB_PHASE_W];
        sel_has_data = bus.i_req_has_data[i];
      end
    end
  end

`ifdef SB_SCHED_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  ptr_q <= '0;
    else if (take) ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  // Pattern wins in IDLE; nothing preempts a word already on the line.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ack_d   = '0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_pattern_req) begin
          state_d = PATTERN;
        end else if (|bus.i_req) begin
          state_d = HDR;
          ack_d   = grant;
          take    = 1'b1;
        end
      end
      PATTERN: if (bus.i_tx_ready && !bus.i_pattern_req) state_d = POST_STATE;
      HDR:     if (bus.i_tx_ready) state_d = has_data_q ? DATA : POST_STATE;
      DATA:    if (bus.i_tx_ready) state_d = POST_STATE;
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - SB_GAP_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GAP && state_q != GAP) gap_d = GAP_LOAD;
  end

  // Header comes straight from the granted requester on the grant edge, then is held.
  always_comb begin
    phase_d = '0;
    case (state_d)
      HDR:     phase_d = (state_q == IDLE) ? sel_hdr : phase_q;
      DATA:    phase_d = data_q;
      default: phase_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      ack_q      <= '0;
      pat_q      <= 1'b0;
      pkt_q      <= 1'b0;
      phase_q    <= '0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      has_data_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      pat_q   <= (state_d == PATTERN);
      pkt_q   <= (state_d == HDR) || (state_d == DATA);
      phase_q <= phase_d;
      busy_q  <= (state_d != IDLE);
      if (take) begin
        data_q     <= sel_data;
        has_data_q <= sel_has_data;
      end
    end
  end

  assign bus.o_req_ack       = ack_q;
  assign bus.o_pattern_valid = pat_q;
  assign bus.o_packet_valid  = pkt_q;
  assign bus.o_packet_phase  = phase_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_state         = state_q;
endmodule
